// File: rtl/rom_step_ctrl_pkg.sv
// Shared types and constants for the ROM step controller.
package rom_step_ctrl_pkg;

    // state | meaning
    // IDLE  | waiting for a step request
    // READ  | one-cycle ROM read strobe, latency counter loaded
    // WAIT  | counting down the ROM read latency
    // PUSH  | word presented to the display, waiting for ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_PUSH = 2'd3
    } state_t;

    localparam logic [7:0] DROP_MAX = 8'd255;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ROM_LAT = 1;
    localparam int DEF_DB_MAX  = 50000;

endpackage

// File: rtl/rom_step_ctrl_if.sv
// ROM read bus and display valid/ready handshake.
interface rom_step_ctrl_if
    import rom_step_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_rd_o;
    logic [DATA_W-1:0] rom_data_i;
    logic [DATA_W-1:0] disp_data_o;
    logic              disp_vld_o;
    logic              disp_rdy_i;

    modport master (
        output rom_addr_o, rom_rd_o, disp_data_o, disp_vld_o,
        input  rom_data_i, disp_rdy_i
    );

    modport slave (
        input  rom_addr_o, rom_rd_o, disp_data_o, disp_vld_o,
        output rom_data_i, disp_rdy_i
    );
endinterface

// File: rtl/rom_step_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchroniser plus stability counter.
module btn_debounce #(
    parameter int DB_MAX = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);
    localparam int CW = (DB_MAX > 1) ? $clog2(DB_MAX) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // bring the raw button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], btn};
    end

    // accept a new level only after it has been stable long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync[1] == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_MAX - 1)) begin
            level <= sync[1];
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/rom_step_ctrl_re_detect.sv
// Rising-edge detector: one-cycle pulse per 0->1 transition of d.
module re_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic [1:0] s;

    // shift the input history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s <= 2'b00;
        else        s <= {s[0], d};
    end

    assign pulse = ~s[1] & s[0];
endmodule

// File: rtl/rom_step_ctrl.sv
// Turns refresh edges (auto) or button presses (manual) into single ROM
// reads and presents each word to the display over valid/ready.
module rom_step_ctrl
    import rom_step_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = DEF_ROM_LAT,
    parameter int DB_MAX  = DEF_DB_MAX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 refresh_i,
    input  logic                 btn_next_i,
    input  logic                 btn_mode_i,
    rom_step_ctrl_if.master      bus,
    output logic                 auto_mode_o,
    output logic                 busy_o,
    output logic [7:0]           drop_cnt_o
);
    logic [1:0]        ref_sync;
    logic              ref_pulse, next_pulse, mode_pulse;
    logic              next_lvl, mode_lvl;
    logic              step;

    state_t            state, state_n;
    logic [1:0]        wait_cnt, wait_cnt_n;
    logic              pending, pending_n;
    logic [7:0]        drop_cnt, drop_cnt_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] ddata, ddata_n;
    logic              dvld, dvld_n;

    // refresh is a clock-like signal, so it is only synchronised
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_sync <= 2'b00;
        else        ref_sync <= {ref_sync[0], refresh_i};
    end

    btn_debounce #(.DB_MAX(DB_MAX)) u_db_next (
        .clk(clk), .rst_n(rst_n), .btn(btn_next_i), .level(next_lvl));
    btn_debounce #(.DB_MAX(DB_MAX)) u_db_mode (
        .clk(clk), .rst_n(rst_n), .btn(btn_mode_i), .level(mode_lvl));

    re_detect u_re_ref  (.clk(clk), .rst_n(rst_n), .d(ref_sync[1]), .pulse(ref_pulse));
    re_detect u_re_next (.clk(clk), .rst_n(rst_n), .d(next_lvl),    .pulse(next_pulse));
    re_detect u_re_mode (.clk(clk), .rst_n(rst_n), .d(mode_lvl),    .pulse(mode_pulse));

    // mode toggles one cycle after the mode pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) auto_mode_o <= 1'b1;
        else        auto_mode_o <= auto_mode_o ^ mode_pulse;
    end

    // the pre-toggle mode selects which trigger counts
    assign step = (ref_pulse & auto_mode_o) | (next_pulse & ~auto_mode_o);

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 2'd0;
            pending  <= 1'b0;
            drop_cnt <= 8'd0;
            addr     <= '0;
            ddata    <= '0;
            dvld     <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            pending  <= pending_n;
            drop_cnt <= drop_cnt_n;
            addr     <= addr_n;
            ddata    <= ddata_n;
            dvld     <= dvld_n;
        end
    end

    // next-state, request queuing and datapath updates
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        pending_n  = pending;
        drop_cnt_n = drop_cnt;
        addr_n     = addr;
        ddata_n    = ddata;
        dvld_n     = dvld;

        // one request can be held; further ones while busy are dropped
        if (state != ST_IDLE && step) begin
            if (!pending)
                pending_n = 1'b1;
            else if (drop_cnt != DROP_MAX)
                drop_cnt_n = drop_cnt + 8'd1;
        end

        case (state)
            ST_IDLE: begin
                if (step || pending) begin
                    state_n   = ST_READ;
                    pending_n = 1'b0;
                end
            end
            ST_READ: begin
                wait_cnt_n = 2'(ROM_LAT - 1);
                state_n    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    ddata_n = bus.rom_data_i;
                    dvld_n  = 1'b1;
                    state_n = ST_PUSH;
                end else begin
                    wait_cnt_n = wait_cnt - 2'd1;
                end
            end
            ST_PUSH: begin
                if (bus.disp_rdy_i) begin
                    dvld_n = 1'b0;
                    addr_n = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
                    if (pending) begin
                        state_n   = ST_READ;
                        pending_n = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.rom_addr_o  = addr;
    assign bus.rom_rd_o    = (state == ST_READ);
    assign bus.disp_data_o = ddata;
    assign bus.disp_vld_o  = dvld;
    assign busy_o          = (state != ST_IDLE);
    assign drop_cnt_o      = drop_cnt;
endmodule

// File: tb/tb_rom_step_ctrl.sv
// Scoreboard bench for rom_step_ctrl with ROM_LAT=2 and a short debounce.
module tb_rom_step_ctrl;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;
    localparam int DATA_W  = 8;
    localparam int ROM_LAT = 2;
    localparam int DB_MAX  = 500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic refresh_i = 1'b0;
    logic btn_next_i = 1'b0;
    logic btn_mode_i = 1'b0;
    logic auto_mode_o, busy_o;
    logic [7:0] drop_cnt_o;

    rom_step_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_step_ctrl #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W),
        .ROM_LAT(ROM_LAT), .DB_MAX(DB_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .refresh_i(refresh_i),
        .btn_next_i(btn_next_i), .btn_mode_i(btn_mode_i),
        .bus(bus), .auto_mode_o(auto_mode_o), .busy_o(busy_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [16] = '{8'hA5, 8'h3C, 8'h5A, 8'h69, 8'h96, 8'hC3, 8'h0F, 8'hF0,
                             8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h01};

    // ROM model: word valid exactly ROM_LAT cycles after the read strobe
    logic [7:0] dpipe0 = 8'h00, dpipe1 = 8'h00;
    logic       vpipe0 = 1'b0, vpipe1 = 1'b0;
    always @(posedge clk) begin
        dpipe0 <= rom[bus.rom_addr_o];
        vpipe0 <= bus.rom_rd_o;
        dpipe1 <= dpipe0;
        vpipe1 <= vpipe0;
    end
    assign bus.rom_data_i = vpipe1 ? dpipe1 : 8'hEE;

    int n_vec = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int toggles = 0;
    logic prev_auto = 1'b1;
    logic [11:0] sb_q[$];
    logic [3:0] exp_addr = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp();
        sb_q.push_back({exp_addr, rom[exp_addr]});
        exp_addr = (exp_addr == 4'(DEPTH - 1)) ? 4'd0 : exp_addr + 4'd1;
    endtask

    task automatic pulse_refresh();
        refresh_i = 1'b1;
        repeat (8) @(negedge clk);
        refresh_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input bit which_mode);
        if (which_mode) btn_mode_i = 1'b1; else btn_next_i = 1'b1;
        repeat (600) @(negedge clk);
        if (which_mode) btn_mode_i = 1'b0; else btn_next_i = 1'b0;
        repeat (600) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 4'd0;
        @(negedge clk);
    endtask

    // monitor: samples between edges, pops one expectation per handshake
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (bus.rom_rd_o) rd_cnt++;
            if (auto_mode_o != prev_auto) toggles++;
            if (bus.disp_vld_o && bus.disp_rdy_i) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data %0h addr %0h, expected none",
                             bus.disp_data_o, bus.rom_addr_o);
                end else begin
                    logic [11:0] e;
                    e = sb_q.pop_front();
                    check("word_data", int'(bus.disp_data_o), int'(e[7:0]));
                    check("word_addr", int'(bus.rom_addr_o), int'(e[11:8]));
                end
            end
        end
        prev_auto = auto_mode_o;
    end

    initial begin
        int first_rd, first_vld, r0, t0;
        bus.disp_rdy_i = 1'b1;
        @(negedge clk);
        apply_reset();

        // idle after reset
        repeat (100) @(negedge clk);
        check("rst_addr", int'(bus.rom_addr_o), 0);
        check("rst_data", int'(bus.disp_data_o), 0);
        check("rst_vld", int'(bus.disp_vld_o), 0);
        check("rst_auto", int'(auto_mode_o), 1);
        check("rst_busy", int'(busy_o), 0);
        check("rst_drop", int'(drop_cnt_o), 0);
        check("rst_no_rd", rd_cnt, 0);

        // single auto step, latency measured from the raw refresh edge:
        // 2 sync + 1 detector cycles to the pulse, then rd at +1, vld at +4
        push_exp();
        first_rd = 0;
        first_vld = 0;
        r0 = rd_cnt;
        refresh_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rom_rd_o && first_rd == 0) first_rd = k;
            if (bus.disp_vld_o && first_vld == 0) first_vld = k;
            if (k == 8) check("lat_addr_after", int'(bus.rom_addr_o), 1);
        end
        refresh_i = 1'b0;
        repeat (4) @(negedge clk);
        check("lat_rd_cycle", first_rd, 4);
        check("lat_vld_cycle", first_vld, 7);
        check("lat_rd_count", rd_cnt - r0, 1);

        // backpressure: one pending, two dropped
        bus.disp_rdy_i = 1'b0;
        push_exp();
        pulse_refresh();
        check("bp_vld_held", int'(bus.disp_vld_o), 1);
        push_exp();
        pulse_refresh();
        pulse_refresh();
        pulse_refresh();
        check("bp_drop_cnt", int'(drop_cnt_o), 2);
        check("bp_data_held", int'(bus.disp_data_o), 8'h3C);
        check("bp_addr_held", int'(bus.rom_addr_o), 1);
        bus.disp_rdy_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_pending_rd", int'(bus.rom_rd_o), 1);
        check("bp_pending_addr", int'(bus.rom_addr_o), 2);
        repeat (10) @(negedge clk);
        check("bp_idle", int'(busy_o), 0);

        // bouncing mode button never settles long enough
        t0 = toggles;
        for (int i = 0; i < 20; i++) begin
            btn_mode_i = ~btn_mode_i;
            repeat (100) @(negedge clk);
        end
        check("bounce_auto", int'(auto_mode_o), 1);
        btn_mode_i = 1'b1;
        repeat (600) @(negedge clk);
        check("db_auto", int'(auto_mode_o), 0);
        btn_mode_i = 1'b0;
        repeat (600) @(negedge clk);
        check("db_toggles", toggles - t0, 1);

        // manual mode: refresh ignored, button steps
        r0 = rd_cnt;
        pulse_refresh();
        pulse_refresh();
        check("man_refresh_ignored", rd_cnt - r0, 0);
        push_exp();
        press(1'b0);
        check("man_next_rd", rd_cnt - r0, 1);
        press(1'b1);
        check("back_to_auto", int'(auto_mode_o), 1);

        // async reset while in WAIT discards the in-flight word
        refresh_i = 1'b1;
        repeat (5) @(negedge clk);
        check("wait_busy", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy_o), 0);
        check("arst_addr", int'(bus.rom_addr_o), 0);
        check("arst_data", int'(bus.disp_data_o), 0);
        check("arst_vld", int'(bus.disp_vld_o), 0);
        check("arst_rd", int'(bus.rom_rd_o), 0);
        check("arst_drop", int'(drop_cnt_o), 0);
        refresh_i = 1'b0;
        @(negedge clk);
        apply_reset();
        push_exp();
        pulse_refresh();

        // address wrap after DEPTH steps from 0
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_exp();
            pulse_refresh();
        end
        check("wrap_addr", int'(bus.rom_addr_o), 0);
        push_exp();
        pulse_refresh();
        check("wrap_addr_after17", int'(bus.rom_addr_o), 1);

        repeat (10) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_step_ctrl.md
Name: rom_step_ctrl

Overview:
- Sequences ROM reads for the display path of the ROM lab.
- Converts a slow refresh clock (auto mode) or a manual push-button (manual mode) into single-step read requests.
- Each request fetches one ROM word, waits the ROM read latency, and presents the word to the display stage with a valid/ready handshake.
- A second button toggles auto/manual mode. Raw inputs are synchronised, buttons debounced, and every trigger is rising-edge detected.

Parameters:
- ADDR_W, 4, ROM address width.
- DEPTH, 16, number of ROM words used; address wraps from DEPTH-1 to 0. Must satisfy DEPTH <= 2**ADDR_W.
- DATA_W, 8, ROM word width.
- ROM_LAT, 1, ROM read latency in cycles, from the rom_rd_o cycle to data valid. Range 1..4.
- DB_MAX, 50000, cycles a synchronised button level must stay stable before it is accepted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- refresh_i  in  1  raw slow refresh clock, asynchronous to clk
- btn_next_i  in  1  raw manual-step button, high active
- btn_mode_i  in  1  raw mode-toggle button, high active
- rom_addr_o  out  ADDR_W  ROM address
- rom_rd_o  out  1  one-cycle ROM read strobe
- rom_data_i  in  DATA_W  ROM read data
- disp_data_o  out  DATA_W  word presented to the display
- disp_vld_o  out  1  disp_data_o valid
- disp_rdy_i  in  1  display accepts the word
- auto_mode_o  out  1  1 = auto (refresh-driven), 0 = manual
- busy_o  out  1  FSM not in IDLE
- drop_cnt_o  out  8  saturating count of discarded step requests

Behaviour:
- Reset values: rom_addr_o=0, rom_rd_o=0, disp_data_o=0, disp_vld_o=0, auto_mode_o=1, busy_o=0, drop_cnt_o=0. FSM=IDLE, pending=0, debounced levels=0, sync flops=0.
- Reset asserted mid-operation aborts everything immediately. An in-flight ROM word is discarded.
- Input conditioning:
  - All three raw inputs pass through 2-flop synchronisers.
  - Each button has a debounce counter: it counts while the synchronised level differs from the debounced level, and clears when they match.
  - On reaching DB_MAX-1 the debounced level takes the new value and the counter clears.
  - Each conditioned signal (refresh and both debounced buttons) feeds a rising-edge detector: 2-bit shift register, pulse = ~s[1] & s[0], exactly one clk cycle per 0->1 transition.
- Mode: a btn_mode pulse toggles auto_mode_o on the next cycle.
- Step request:
  - step = refresh pulse AND auto_mode_o, OR next pulse AND NOT auto_mode_o.
  - Uses the current (pre-toggle) mode when a mode pulse coincides.
- FSM states: IDLE, READ, WAIT, PUSH.
  - IDLE: on step (or pending=1), go to READ and clear pending.
  - READ: rom_rd_o=1 for exactly one cycle; rom_addr_o is stable; WAIT counter loads ROM_LAT-1.
  - WAIT: count down. At zero, capture rom_data_i into disp_data_o, set disp_vld_o=1, go to PUSH.
  - PUSH:
    - disp_vld_o and disp_data_o are held until disp_rdy_i=1.
    - On handshake: disp_vld_o=0 and rom_addr_o = (rom_addr_o==DEPTH-1) ? 0 : rom_addr_o+1.
    - Next state is READ if pending (pending cleared), else IDLE.
  - Latency: step pulse at cycle t gives rom_rd_o at t+1 and disp_vld_o at t+2+ROM_LAT.
- Requests while busy:
  - A step in READ/WAIT/PUSH sets pending if pending=0.
  - If pending=1 the step is dropped and drop_cnt_o increments, saturating at 255.
  - A step in the PUSH handshake cycle counts as arriving while busy.
- rom_addr_o changes only on a PUSH handshake. disp_data_o changes only on WAIT exit.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, READ=2'd1, WAIT=2'd2, PUSH=2'd3), the DROP_MAX=8'd255 constant, and default parameter constants.
- Natural sub-module: the existing re_detect edge detector, instantiated three times.
- A small btn_debounce sub-module (synchroniser + counter) instantiated twice.

Test Plan:
- Reset, then apply nothing for 100 cycles -> all outputs at reset values, auto_mode_o=1, rom_rd_o never pulses.
- Auto mode, ROM_LAT=2, ROM[0]=8'hA5, one refresh rising edge, disp_rdy_i=1:
  - one rom_rd_o at addr 0;
  - disp_vld_o with data 8'hA5 four cycles after the edge pulse;
  - rom_addr_o becomes 1 after the handshake.
- DEPTH=16, 16 serviced steps from addr 0 -> rom_addr_o returns to 0. The 17th read fetches ROM[0].
- Button bounce on btn_mode_i (toggles every 100 cycles for 2000 cycles), then a stable high longer than DB_MAX (reduced to 500 in sim) -> exactly one toggle (auto_mode_o=0). Subsequent refresh edges are ignored; a clean btn_next press yields one read.
- disp_rdy_i held 0 while 3 step pulses arrive during PUSH -> first sets pending, next 2 dropped, drop_cnt_o=2. On release, a second read starts immediately from READ at addr+1.
- rst_n asserted in WAIT -> outputs go to reset values asynchronously. After release, the first step reads addr 0.
